// File: rtl/mul_pkg.sv
// Shared types, sizes and helpers for the iterative carry-save multiplier.
package mul_pkg;

    localparam int unsigned MUL_XLEN   = 32;
    localparam int unsigned MUL_ITERS  = MUL_XLEN / 2;
    localparam int unsigned MUL_PROD_W = 2 * MUL_XLEN;
    localparam int unsigned MUL_CNT_W  = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREP    = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_NEGATE  = 3'd4,
        ST_DONE    = 3'd5
    } mul_state_e;

    function automatic logic a_is_signed(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic b_is_signed(input mul_op_e op);
        return (op == OP_MULH);
    endfunction

    // MUL returns the low word, every other op the high word.
    function automatic logic [MUL_XLEN-1:0] select_result(input mul_op_e op,
                                                          input logic [MUL_PROD_W-1:0] prod);
        return (op == OP_MUL) ? prod[MUL_XLEN-1:0] : prod[MUL_PROD_W-1:MUL_XLEN];
    endfunction

endpackage

// File: rtl/mul_csa_42_32.sv
// 32-bit 4:2 compressor slice; the lateral carry ripples one bit per column only.
module mul_csa_42_32 (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic [31:0] x4,
    input  logic        cin,
    output logic [31:0] s,
    output logic [31:0] c,
    output logic        cout
);

    logic [31:0] s1;
    logic [31:0] co;
    logic [31:0] ci;

    always_comb begin
        s1   = x1 ^ x2 ^ x3;
        co   = (x1 & x2) | (x1 & x3) | (x2 & x3);
        ci   = {co[30:0], cin};
        s    = s1 ^ x4 ^ ci;
        c    = (s1 & x4) | (s1 & ci) | (x4 & ci);
        cout = co[31];
    end

endmodule

// File: rtl/mul_csa_stage_64.sv
// 64-bit 4:2 compressor: two 32-bit slices chained through the lateral carry.
module mul_csa_stage_64
    import mul_pkg::*;
(
    input  logic [MUL_PROD_W-1:0] in0,
    input  logic [MUL_PROD_W-1:0] in1,
    input  logic [MUL_PROD_W-1:0] in2,
    input  logic [MUL_PROD_W-1:0] in3,
    output logic [MUL_PROD_W-1:0] s,
    output logic [MUL_PROD_W-1:0] c,
    output logic                  cout
);

    logic mid_carry;

    mul_csa_42_32 u_lo (
        .x1  (in0[MUL_XLEN-1:0]),
        .x2  (in1[MUL_XLEN-1:0]),
        .x3  (in2[MUL_XLEN-1:0]),
        .x4  (in3[MUL_XLEN-1:0]),
        .cin (1'b0),
        .s   (s[MUL_XLEN-1:0]),
        .c   (c[MUL_XLEN-1:0]),
        .cout(mid_carry)
    );

    mul_csa_42_32 u_hi (
        .x1  (in0[MUL_PROD_W-1:MUL_XLEN]),
        .x2  (in1[MUL_PROD_W-1:MUL_XLEN]),
        .x3  (in2[MUL_PROD_W-1:MUL_XLEN]),
        .x4  (in3[MUL_PROD_W-1:MUL_XLEN]),
        .cin (mid_carry),
        .s   (s[MUL_PROD_W-1:MUL_XLEN]),
        .c   (c[MUL_PROD_W-1:MUL_XLEN]),
        .cout(cout)
    );

endmodule

// File: rtl/mul_csa_sequencer.sv
// Iterative RISC-V M-extension multiplier: radix-4 carry-save accumulation,
// then a single carry-propagate resolve and optional sign correction.
module mul_csa_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int unsigned PROD_W = 2 * XLEN;

    mul_state_e          state_q, state_d;
    mul_op_e             op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_q, neg_d;
    logic [PROD_W-1:0]   sum_q, sum_d;
    logic [PROD_W-1:0]   carry_q, carry_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_data_q, resp_data_d;

    logic [PROD_W-1:0]   pp0, pp1, csa_s, csa_c;
    logic                unused_csa_cout;
    logic                unused_funct3;
    mul_op_e             req_op;

    assign unused_funct3 = req_funct3[2];
    assign req_op        = mul_op_e'(req_funct3[1:0]);

    // Two multiplier bits retired per ACCUM cycle.
    always_comb begin
        pp0 = b_q[{cnt_q, 1'b0}] ? (PROD_W'(a_q) << {cnt_q, 1'b0}) : '0;
        pp1 = b_q[{cnt_q, 1'b1}] ? (PROD_W'(a_q) << {cnt_q, 1'b1}) : '0;
    end

    mul_csa_stage_64 u_csa (
        .in0 (sum_q),
        .in1 (carry_q << 1),
        .in2 (pp0),
        .in3 (pp1),
        .s   (csa_s),
        .c   (csa_c),
        .cout(unused_csa_cout)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        tag_d        = tag_q;
        a_d          = a_q;
        b_d          = b_q;
        neg_d        = neg_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    tag_d   = req_tag;
                    a_d     = req_rs1;
                    b_d     = req_rs2;
                    neg_d   = (a_is_signed(req_op) & req_rs1[XLEN-1])
                            ^ (b_is_signed(req_op) & req_rs2[XLEN-1]);
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                if (a_is_signed(op_q) && a_q[XLEN-1]) a_d = ~a_q + XLEN'(1);
                if (b_is_signed(op_q) && b_q[XLEN-1]) b_d = ~b_q + XLEN'(1);
                sum_d   = '0;
                carry_d = '0;
                cnt_d   = '0;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                sum_d   = csa_s;
                carry_d = csa_c;
                cnt_d   = cnt_q + MUL_CNT_W'(1);
                if (cnt_q == MUL_CNT_W'(MUL_ITERS - 1)) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                prod_d = sum_q + (carry_q << 1);
                if (neg_q) begin
                    state_d = ST_NEGATE;
                end else begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = select_result(op_q, prod_d);
                end
            end
            ST_NEGATE: begin
                prod_d       = ~prod_q + PROD_W'(1);
                state_d      = ST_DONE;
                resp_valid_d = 1'b1;
                resp_data_d  = select_result(op_q, prod_d);
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase

        // Flush wins over everything, including a DONE-state handshake.
        if (flush) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_MUL;
            tag_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            neg_q        <= 1'b0;
            sum_q        <= '0;
            carry_q      <= '0;
            prod_q       <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            a_q          <= a_d;
            b_q          <= b_d;
            neg_q        <= neg_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            prod_q       <= prod_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !flush;
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = tag_q;

endmodule

// File: tb/tb_mul_csa_sequencer.sv
// Directed self-checking bench for mul_csa_sequencer.
module tb_mul_csa_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mul_csa_sequencer #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_funct3(req_funct3),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_tag   (req_tag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_tag  (resp_tag),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        be = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ae * be;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        logic n;
        n = ((op == 2'b01 || op == 2'b10) & a[31]) ^ ((op == 2'b01) & b[31]);
        return n ? 19 : 18;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = tag;
        while (!ok && n < 50) begin
            ok = (req_ready === 1'b1);
            @(posedge clk); @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (resp_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({req_ready, resp_valid, busy} !== 3'b100 || resp_data !== 32'h0 || resp_tag !== 5'h0) begin
            err_cnt++;
            $display("FAIL reset_hold: ready/valid/busy=%b data=%h tag=%h, want 100/0/0",
                     {req_ready, resp_valid, busy}, resp_data, resp_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({req_ready, resp_valid, busy} !== 3'b100) begin
            err_cnt++;
            $display("FAIL reset_release: ready/valid/busy=%b, want 100", {req_ready, resp_valid, busy});
        end
    endtask

    task automatic test_arith;
        logic [2:0]  f3 [10] = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b010,
                                 3'b100, 3'b001, 3'b011, 3'b010, 3'b001};
        logic [31:0] av [10] = '{32'h7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
                                 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0, 32'h2, 32'hFFFFFFFF};
        logic [31:0] bv [10] = '{32'h6, 32'h2, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h5, 32'h5, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ev [10] = '{32'h0000002A, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFE, 32'h80000000,
                                 32'hFFFFFFF1, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0};
        int          lv [10] = '{18, 19, 18, 18, 19, 18, 19, 18, 18, 18};
        bit ok, bok;
        int cyc;
        logic [4:0] tag;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tag = 5'(i + 3);
            issue(f3[i], av[i], bv[i], tag, ok);
            wait_resp(cyc, bok);
            vec_cnt++;
            if (resp_data !== ev[i] || resp_tag !== tag) begin
                err_cnt++;
                $display("FAIL arith[%0d] data/tag: got %h/%h, want %h/%h", i, resp_data, resp_tag, ev[i], tag);
            end
            vec_cnt++;
            if (!ok || cyc != lv[i] || !bok) begin
                err_cnt++;
                $display("FAIL arith[%0d] latency: accepted=%0d lat=%0d busy_ok=%0d, want 1/%0d/1",
                         i, ok, cyc, bok, lv[i]);
            end
            @(posedge clk); @(negedge clk);
            vec_cnt++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL arith[%0d] release: valid=%b ready=%b, want 0/1", i, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_stall;
        bit ok, bok;
        int cyc;
        resp_ready = 1'b0;
        issue(3'b000, 32'h12345678, 32'h10, 5'h15, ok);
        wait_resp(cyc, bok);
        for (int k = 0; k < 3; k++) begin
            vec_cnt++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h23456780 || resp_tag !== 5'h15 || req_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL stall[%0d]: valid=%b data=%h tag=%h ready=%b, want 1/23456780/15/0",
                         k, resp_valid, resp_data, resp_tag, req_ready);
            end
            @(posedge clk); @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        vec_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_release: valid=%b ready=%b busy=%b, want 0/1/0", resp_valid, req_ready, busy);
        end
        issue(3'b011, 32'h00010000, 32'h00010000, 5'h16, ok);
        wait_resp(cyc, bok);
        vec_cnt++;
        if (!ok || resp_data !== 32'h1 || resp_tag !== 5'h16 || cyc != 18) begin
            err_cnt++;
            $display("FAIL stall_next: ok=%0d data=%h tag=%h lat=%0d, want 1/00000001/16/18",
                     ok, resp_data, resp_tag, cyc);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_flush;
        bit ok, bok, seen;
        int cyc;
        resp_ready = 1'b1;
        issue(3'b000, 32'h9, 32'h9, 5'h1A, ok);
        repeat (6) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_ready_low: ready=%b, want 0", req_ready);
        end
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        #1;
        vec_cnt++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_accum: ready=%b busy=%b valid=%b, want 1/0/0", req_ready, busy, resp_valid);
        end
        seen = 1'b0;
        repeat (25) begin @(posedge clk); @(negedge clk); if (resp_valid === 1'b1) seen = 1'b1; end
        vec_cnt++;
        if (seen) begin
            err_cnt++;
            $display("FAIL flush_no_resp: resp_valid seen=1, want 0");
        end
        flush = 1'b1; req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h1; req_rs2 = 32'h1;
        #1;
        vec_cnt++;
        if (req_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_idle_ready: ready=%b, want 0", req_ready);
        end
        @(posedge clk); @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_idle_accept: busy=%b, want 0", busy);
        end
        flush = 1'b0; req_valid = 1'b0;
        issue(3'b000, 32'h3, 32'h5, 5'h1B, ok);
        wait_resp(cyc, bok);
        vec_cnt++;
        if (!ok || resp_data !== 32'hF || resp_tag !== 5'h1B || cyc != 18) begin
            err_cnt++;
            $display("FAIL flush_then_mul: ok=%0d data=%h tag=%h lat=%0d, want 1/0000000f/1b/18",
                     ok, resp_data, resp_tag, cyc);
        end
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        issue(3'b000, 32'h2, 32'h2, 5'h1C, ok);
        wait_resp(cyc, bok);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        vec_cnt++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_done: valid=%b busy=%b, want 0/0", resp_valid, busy);
        end
    endtask

    task automatic test_async_reset;
        bit ok, seen;
        resp_ready = 1'b1;
        issue(3'b011, 32'hFFFFFFFF, 32'h3, 5'h0F, ok);
        repeat (8) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({req_ready, resp_valid, busy} !== 3'b100 || resp_data !== 32'h0 || resp_tag !== 5'h0) begin
            err_cnt++;
            $display("FAIL async_reset: ready/valid/busy=%b data=%h tag=%h, want 100/0/0",
                     {req_ready, resp_valid, busy}, resp_data, resp_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin @(posedge clk); @(negedge clk); if (resp_valid === 1'b1) seen = 1'b1; end
        vec_cnt++;
        if (seen || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset_no_resp: seen=%0d busy=%b, want 0/0", seen, busy);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, bok;
        int cyc, stall;
        logic [1:0]  op;
        logic [31:0] a, b, exp;
        logic [4:0]  tag;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = (i % 5 == 0) ? 32'h80000000 : $urandom;
            b   = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
            tag = 5'($urandom);
            exp = ref_mul(op, a, b);
            resp_ready = 1'b0;
            issue({1'($urandom_range(0, 1)), op}, a, b, tag, ok);
            wait_resp(cyc, bok);
            vec_cnt++;
            if (!ok || resp_data !== exp || resp_tag !== tag || cyc != ref_lat(op, a, b)) begin
                err_cnt++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: data=%h tag=%h lat=%0d, want %h/%h/%0d",
                         i, op, a, b, resp_data, resp_tag, cyc, exp, tag, ref_lat(op, a, b));
            end
            stall = $urandom_range(0, 3);
            repeat (stall) begin @(posedge clk); @(negedge clk); end
            resp_ready = 1'b1;
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000;
        req_rs1 = '0; req_rs2 = '0; req_tag = '0; resp_ready = 1'b1;
        test_reset;
        test_arith;
        test_stall;
        test_flush;
        test_async_reset;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
